// File: rtl/gb_cpu_fetch_unit.sv
// gb_cpu_fetch_unit: instruction fetch stage feeding the CPU decoder.
//   Owns the program counter, issues byte reads, folds the 0xCB prefix into
//   a single decoder handshake and accepts redirects / operand increments.
//
// Optional feature macro: GB_CPU_FETCH_HALT_EN (adds halt_req, irq_pending
// and a HALTED state; absent when the macro is undefined).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   mem_addr            read address (always the current pc)
//   mem_rd_req          read request, held until mem_rd_valid
//   mem_rd_data/valid   read return
//   opcode, cb_prefix   instruction byte and extended-set flag
//   instr_valid/ready   decoder handshake
//   instr_pc            address of the instruction's first byte
//   pc                  current program counter
//   pc_inc              operand byte consumed (honoured in HOLD only)
//   pc_load, pc_load_value  redirect, highest priority
//   halt_req, irq_pending   (GB_CPU_FETCH_HALT_EN only)
module gb_cpu_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [7:0]  CB_PREFIX = 8'hCB
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_rd_req,
    input  logic [7:0]  mem_rd_data,
    input  logic        mem_rd_valid,
    output logic [7:0]  opcode,
    output logic        cb_prefix,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_pc,
    output logic [15:0] pc,
    input  logic        pc_inc,
    input  logic        pc_load,
    input  logic [15:0] pc_load_value
`ifdef GB_CPU_FETCH_HALT_EN
    ,
    input  logic        halt_req,
    input  logic        irq_pending
`endif
);

    localparam int unsigned PC_W   = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_FETCH_CB = 2'd1,
        ST_HOLD     = 2'd2
`ifdef GB_CPU_FETCH_HALT_EN
        ,
        ST_HALTED   = 2'd3
`endif
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                cb_flag;
    logic                cb_flag_d;
    logic [PC_W-1:0]     pc_d;
    logic [PC_W-1:0]     instr_pc_d;
    logic [BYTE_W-1:0]   opcode_d;
    logic                cb_prefix_d;
    logic                instr_valid_d;
    logic                mem_rd_req_d;
    logic                rd_fire;
    logic                is_prefix;
    logic                consume;

    // A byte is only taken while a request is actually outstanding.
    assign rd_fire   = mem_rd_req && mem_rd_valid;
    assign is_prefix = (mem_rd_data == CB_PREFIX) && !cb_flag;
    assign consume   = instr_ready && instr_valid;

    // pc is a register, so the address bus is registered too.
    assign mem_addr = pc;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect overrides everything.
    always_comb begin
        state_next = state;
        if (pc_load) begin
            state_next = ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (rd_fire) begin
                        state_next = is_prefix ? ST_FETCH_CB : ST_HOLD;
                    end
                end
                ST_FETCH_CB: begin
                    if (rd_fire) begin
                        state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (consume) begin
`ifdef GB_CPU_FETCH_HALT_EN
                        state_next = halt_req ? ST_HALTED : ST_FETCH;
`else
                        state_next = ST_FETCH;
`endif
                    end
                end
`ifdef GB_CPU_FETCH_HALT_EN
                ST_HALTED: begin
                    if (irq_pending) begin
                        state_next = ST_FETCH;
                    end
                end
`endif
                default: state_next = ST_FETCH;
            endcase
        end
    end

    // Output / datapath next values.
    always_comb begin
        pc_d          = pc;
        opcode_d      = opcode;
        cb_prefix_d   = cb_prefix;
        instr_pc_d    = instr_pc;
        instr_valid_d = instr_valid;
        cb_flag_d     = cb_flag;
        if (pc_load) begin
            // Any in-flight byte (including half a CB pair) is dropped.
            pc_d          = pc_load_value;
            instr_valid_d = 1'b0;
            cb_flag_d     = 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (rd_fire) begin
                        pc_d       = pc + PC_W'(1);
                        instr_pc_d = pc;
                        if (is_prefix) begin
                            cb_flag_d = 1'b1;
                        end else begin
                            opcode_d      = mem_rd_data;
                            cb_prefix_d   = 1'b0;
                            instr_valid_d = 1'b1;
                        end
                    end
                end
                ST_FETCH_CB: begin
                    // Second byte is always an extended opcode, even 0xCB.
                    if (rd_fire) begin
                        pc_d          = pc + PC_W'(1);
                        opcode_d      = mem_rd_data;
                        cb_prefix_d   = 1'b1;
                        instr_valid_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (pc_inc) begin
                        pc_d = pc + PC_W'(1);
                    end
                    if (consume) begin
                        instr_valid_d = 1'b0;
                        cb_flag_d     = 1'b0;
                    end
                end
`ifdef GB_CPU_FETCH_HALT_EN
                ST_HALTED: begin
                    instr_valid_d = 1'b0;
                end
`endif
                default: begin
                    instr_valid_d = 1'b0;
                    cb_flag_d     = 1'b0;
                end
            endcase
        end
        // Request is registered so it first rises the cycle after reset.
        mem_rd_req_d = (state_next == ST_FETCH) || (state_next == ST_FETCH_CB);
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr_pc    <= RESET_PC;
            opcode      <= BYTE_W'(0);
            cb_prefix   <= 1'b0;
            instr_valid <= 1'b0;
            cb_flag     <= 1'b0;
            mem_rd_req  <= 1'b0;
        end else begin
            pc          <= pc_d;
            instr_pc    <= instr_pc_d;
            opcode      <= opcode_d;
            cb_prefix   <= cb_prefix_d;
            instr_valid <= instr_valid_d;
            cb_flag     <= cb_flag_d;
            mem_rd_req  <= mem_rd_req_d;
        end
    end

endmodule

// File: tb/tb_gb_cpu_fetch_unit.sv
// Scoreboard bench for gb_cpu_fetch_unit: randomized memory, waits,
// redirects and operand increments checked against an instruction-level model.
module tb_gb_cpu_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [7:0]  CB       = 8'hCB;
    localparam int          NDIR     = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_rd_req;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        mem_rd_valid = 1'b0;
    logic [7:0]  opcode;
    logic        cb_prefix;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_pc;
    logic [15:0] pc;
    logic        pc_inc = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_value = 16'h0000;
`ifdef GB_CPU_FETCH_HALT_EN
    logic        halt_req = 1'b0;
    logic        irq_pending = 1'b0;
`endif

    gb_cpu_fetch_unit #(.RESET_PC(RESET_PC), .CB_PREFIX(CB)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (mem_addr),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .opcode       (opcode),
        .cb_prefix    (cb_prefix),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_pc     (instr_pc),
        .pc           (pc),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .pc_load_value(pc_load_value)
`ifdef GB_CPU_FETCH_HALT_EN
        ,
        .halt_req     (halt_req),
        .irq_pending  (irq_pending)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic        cb;
        logic [15:0] ipc;
        logic [15:0] pc_after;
    } exp_t;

    logic [7:0]  mem [0:65535];
    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] m_pc = RESET_PC;
    bit          halted = 1'b0;
    bit          in_reset = 1'b1;
    int          halt_cnt = 0;
    int          consumed = 0;
    int          dir_idx = 0;
    int          dir_at [NDIR] = '{2, 4, 6};
    logic [15:0] dir_tgt [NDIR] = '{16'h0100, 16'hFFFF, 16'h8000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One instruction as the decoder should see it when fetching from p.
    function automatic exp_t predict(input logic [15:0] p);
        exp_t e;
        logic [15:0] p1;
        p1    = p + 16'd1;
        e.ipc = p;
        if (mem[p] == CB) begin
            e.op       = mem[p1];
            e.cb       = 1'b1;
            e.pc_after = p1 + 16'd1;
        end else begin
            e.op       = mem[p];
            e.cb       = 1'b0;
            e.pc_after = p1;
        end
        return e;
    endfunction

    task automatic expect_from(input logic [15:0] p);
        exp_t e;
        e = predict(p);
        q.push_back(e);
        m_pc = e.pc_after;
    endtask

    task automatic do_reset();
        in_reset    = 1'b1;
        reset       = 1'b1;
        pc_inc      = 1'b0;
        instr_ready = 1'b0;
        pc_load     = 1'b0;
`ifdef GB_CPU_FETCH_HALT_EN
        halt_req    = 1'b0;
        irq_pending = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'(RESET_PC));
        chk("rst_mem_addr", 32'(mem_addr), 32'(RESET_PC));
        chk("rst_instr_pc", 32'(instr_pc), 32'(RESET_PC));
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_cb_prefix", 32'(cb_prefix), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_mem_rd_req", 32'(mem_rd_req), 32'h0);
        reset  = 1'b0;
        q.delete();
        halted = 1'b0;
        expect_from(RESET_PC);
        in_reset = 1'b0;
        @(negedge clk);
        chk("req_after_reset", 32'(mem_rd_req), 32'h1);
    endtask

    // Sequencer behaviour for one cycle, driven at the falling edge.
    task automatic drive_cycle();
        bit          ld;
        logic [15:0] tgt;
        ld          = 1'b0;
        tgt         = 16'h0000;
        pc_inc      = 1'b0;
        instr_ready = 1'b0;
        pc_load     = 1'b0;
`ifdef GB_CPU_FETCH_HALT_EN
        halt_req    = 1'b0;
        irq_pending = 1'b0;
`endif
        if (halted) begin
            chk("halt_req_low", 32'(mem_rd_req), 32'h0);
            chk("halt_valid_low", 32'(instr_valid), 32'h0);
            chk("halt_pc_frozen", 32'(pc), 32'(m_pc));
            pc_inc = 1'($urandom_range(0, 1));
            halt_cnt++;
            if (halt_cnt >= 10) begin
                halted = 1'b0;
                if ($urandom_range(0, 1) == 0) begin
`ifdef GB_CPU_FETCH_HALT_EN
                    irq_pending = 1'b1;
`endif
                    expect_from(m_pc);
                end else begin
                    tgt = 16'($urandom);
                    pc_load = 1'b1;
                    pc_load_value = tgt;
                    q.delete();
                    expect_from(tgt);
                end
            end
        end else if (instr_valid) begin
            if ($urandom_range(0, 3) == 0) begin
                pc_inc = 1'b1;
                m_pc   = m_pc + 16'd1;
            end
            if ($urandom_range(0, 2) == 0) begin
                instr_ready = 1'b1;
                consumed++;
            end
            if (instr_ready && dir_idx < NDIR && consumed >= dir_at[dir_idx]) begin
                ld  = 1'b1;
                tgt = dir_tgt[dir_idx];
                dir_idx++;
            end else if ($urandom_range(0, 15) == 0) begin
                ld  = 1'b1;
                tgt = 16'($urandom);
            end
            if (ld) begin
                pc_load = 1'b1;
                pc_load_value = tgt;
                q.delete();
                expect_from(tgt);
            end else if (instr_ready) begin
`ifdef GB_CPU_FETCH_HALT_EN
                if ($urandom_range(0, 7) == 0) begin
                    halt_req = 1'b1;
                    halted   = 1'b1;
                    halt_cnt = 0;
                end else begin
                    expect_from(m_pc);
                end
`else
                expect_from(m_pc);
`endif
            end
        end else begin
            // Stray pc_inc / instr_ready while fetching must be ignored.
            pc_inc      = ($urandom_range(0, 3) == 0);
            instr_ready = ($urandom_range(0, 3) == 0);
`ifdef GB_CPU_FETCH_HALT_EN
            halt_req    = ($urandom_range(0, 3) == 0);
            irq_pending = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 11) == 0) begin
                tgt = 16'($urandom);
                pc_load = 1'b1;
                pc_load_value = tgt;
                q.delete();
                expect_from(tgt);
            end
        end
    endtask

    // Memory: random 0..2 wait cycles; stray valid pulses while idle.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            mem_rd_valid = 1'b0;
            mem_rd_data  = 8'($urandom);
            if (reset) begin
                wait_cnt = 0;
            end else if (mem_rd_req) begin
                if (wait_cnt == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = mem[mem_addr];
                    wait_cnt     = $urandom_range(0, 2);
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = CB;
            end
        end
    end

    // Monitor: pop on each new instruction, then check it stays stable.
    initial begin
        bit   prev_v;
        bit   have_cur;
        int   idle;
        exp_t cur;
        prev_v   = 1'b0;
        have_cur = 1'b0;
        idle     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || in_reset) begin
                prev_v   = 1'b0;
                have_cur = 1'b0;
                idle     = 0;
            end else begin
                if (instr_valid) begin
                    if (!prev_v) begin
                        if (q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            have_cur = 1'b0;
                            $display("FAIL unexpected_instr: got op %h at pc %h expected none at %0t",
                                     opcode, instr_pc, $time);
                        end else begin
                            cur      = q.pop_front();
                            have_cur = 1'b1;
                        end
                    end
                    if (have_cur) begin
                        chk("opcode", 32'(opcode), 32'(cur.op));
                        chk("cb_prefix", 32'(cb_prefix), 32'(cur.cb));
                        chk("instr_pc", 32'(instr_pc), 32'(cur.ipc));
                        chk("pc_hold", 32'(pc), 32'(m_pc));
                    end
                    idle = 0;
                end else begin
                    have_cur = 1'b0;
                    if (!halted) idle++;
                    if (idle > 40) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL fetch_timeout: got no instr_valid in %0d cycles expected one at %0t",
                                 idle, $time);
                        idle = 0;
                    end
                end
                prev_v = instr_valid;
            end
        end
    end

    initial begin
        int cyc;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = ($urandom_range(0, 3) == 0) ? CB : 8'($urandom);
        end
        mem[16'h0000] = 8'h3C;
        mem[16'h0100] = CB;
        mem[16'h0101] = 8'h37;
        mem[16'hFFFF] = 8'h00;
        mem[16'h8000] = CB;
        mem[16'h8001] = CB;
        cyc = 0;
        do_reset();
        while (consumed < 400 && cyc < 20000) begin
            drive_cycle();
            @(negedge clk);
            cyc++;
            if (cyc == 900) do_reset();
        end
        if (consumed < 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_budget: got %0d instructions expected 400", consumed);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_cpu_fetch_unit.md
Name: gb_cpu_fetch_unit

Overview:
Instruction fetch stage directly upstream of the CPU instruction decoder.
- Owns the program counter and issues byte reads on the memory bus.
- Recognises the 0xCB prefix and fetches the second byte.
- Presents {opcode, cb_prefix} to the decoder with a valid/ready handshake.
- Accepts PC redirects (jumps, calls, returns, interrupts) and PC increments for immediate operands consumed by the M-cycle sequencer.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- CB_PREFIX, 8'hCB, opcode byte treated as the extended-set prefix.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_addr  output  16  read address; equals pc while mem_rd_req=1.
- mem_rd_req  output  1  read request; held until accepted.
- mem_rd_data  input  8  read data; sampled only when mem_rd_valid=1.
- mem_rd_valid  input  1  read completes this cycle.
- opcode  output  8  instruction byte to the decoder.
- cb_prefix  output  1  opcode belongs to the 0xCB-prefixed set.
- instr_valid  output  1  opcode, cb_prefix and instr_pc are valid and stable.
- instr_ready  input  1  sequencer consumes the instruction this cycle.
- instr_pc  output  16  address of the instruction's first byte (the CB byte when prefixed).
- pc  output  16  current program counter.
- pc_inc  input  1  sequencer consumed one operand byte; pc+1.
- pc_load  input  1  redirect request.
- pc_load_value  input  16  redirect target.

Behaviour:
Clock and reset: one clock; reset is asynchronous and active-high. The clock port is clk and the reset port is reset.

Reset values:
- pc=RESET_PC, state=FETCH, cb flag=0.
- opcode=8'h00, cb_prefix=0, instr_valid=0, instr_pc=RESET_PC.
- mem_rd_req=0; it asserts in the first cycle after reset deasserts.
- mem_addr=RESET_PC.

States:
- FETCH
  - mem_rd_req=1, mem_addr=pc.
  - On mem_rd_valid, pc<=pc+1.
  - Byte==CB_PREFIX and cb flag=0: set cb flag, record instr_pc=pc, go to FETCH_CB.
  - Otherwise: opcode<=byte, cb_prefix<=0, instr_pc<=pc, instr_valid<=1, go to HOLD.
- FETCH_CB
  - mem_rd_req=1, mem_addr=pc.
  - On mem_rd_valid: pc<=pc+1, opcode<=byte, cb_prefix<=1, instr_valid<=1, go to HOLD.
  - A second 0xCB byte is a normal extended opcode (0xCB with cb_prefix=1); it is not a new prefix.
- HOLD
  - mem_rd_req=0.
  - opcode, cb_prefix and instr_pc are frozen.
  - pc_inc=1: pc<=pc+1.
  - instr_ready=1: instr_valid<=0, cb flag<=0, go to FETCH. The next request is issued the following cycle.

Latency:
- instr_valid rises on the edge that accepts the final byte.
- Minimum 1 cycle per unprefixed fetch and 2 per prefixed fetch, plus memory wait cycles.

Rules:
- mem_rd_valid while mem_rd_req=0 is ignored.
- pc_inc outside HOLD is ignored.
- instr_ready while instr_valid=0 is ignored.
- PC arithmetic is 16-bit wrap-around: 16'hFFFF+1 = 16'h0000.

Redirect (pc_load) has highest priority in every state:
- pc<=pc_load_value, instr_valid<=0, cb flag<=0, state<=FETCH.
- In FETCH or FETCH_CB, a concurrent mem_rd_valid byte is discarded, including a half-fetched CB pair.
- pc_load together with pc_inc: the load wins and the increment is dropped.
- pc_load together with instr_ready: the instruction counts as consumed and the load wins.

Reset asserted mid-operation returns all state immediately to the reset values. A pending read is abandoned.

Optional Feature:
Macro GB_CPU_FETCH_HALT_EN.

When defined:
- Adds input halt_req (1) and input irq_pending (1), plus state HALTED.
- In HOLD, instr_ready=1 with halt_req=1 enters HALTED.
- In HALTED: mem_rd_req=0, instr_valid=0, pc frozen.
- irq_pending=1 returns to FETCH on the next edge.
- pc_load also exits HALTED.

When undefined: the ports and the HALTED state do not exist.

Test Plan:
1. Release reset with memory returning 8'h3C on the first cycle -> mem_addr=0000, opcode=3C, cb_prefix=0, instr_valid=1 one edge later, pc=0001, instr_pc=0000.
2. Memory holds CB,37 at 0100 with 2 wait cycles each -> a single instr_valid with opcode=37, cb_prefix=1, instr_pc=0100, pc=0102; no valid is seen for the CB byte alone.
3. In HOLD pulse pc_inc twice, then instr_ready -> pc advances by 2; the next request is at the new pc the cycle after ready; opcode stays stable until ready.
4. Assert pc_load=1234 in FETCH_CB in the same cycle as mem_rd_valid -> the byte is discarded, cb flag is cleared, the next request is at 1234, and the next delivered instruction has cb_prefix=0.
5. Fetch at pc=FFFF returning 8'h00 -> pc wraps to 0000 and the next mem_addr=0000.
6. With GB_CPU_FETCH_HALT_EN: instr_ready with halt_req=1 -> mem_rd_req stays 0 for 10 cycles; irq_pending=1 -> the request resumes at the held pc.
